adc_scan_ctrl: RTL

- Parametrised successor to the single-channel LTC2308 reader on DE1-SoC.
- Free-running SPI scanner: round-robin over a runtime channel mask; programmable SCK divider and conversion wait.
- Tags each result with its channel and keeps a per-channel result bank for the HPS/Qsys side.
- Sits between the ADC pins and fabric consumers.

---
 rtl/adc_scan_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: free-running LTC2308 SPI scanner. Walks the channels set in
// ch_mask round-robin, tags each result with the channel it belongs to and
// keeps a per-channel result bank.
// Optional build macro: ADC_AVG4_EN -- report the mean of every 4 results
// per channel instead of each raw result.
//
// state | meaning
// IDLE  | stopped, cs high; waits for enable and a non-empty mask
// CONV  | cs high for CONV_WAIT cycles while the ADC converts
// SHIFT | cs low, 12 SCK periods: config word out, previous result in
// DONE  | one cycle: publish previous frame's result, pick next channel
module adc_scan_ctrl #(
  parameter int CLK_DIV   = 2,
  parameter int NUM_CH    = 8,
  parameter int CONV_WAIT = 80,
  parameter int UNIPOLAR  = 1
) (
  input  logic                   clk_50,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_CH-1:0]      ch_mask,
  output logic                   sck,
  output logic                   cs,
  output logic                   mosi,
  input  logic                   miso,
  output logic [11:0]            sample_data,
  output logic [2:0]             sample_ch,
  output logic                   sample_valid,
  output logic [12*NUM_CH-1:0]   ch_data,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t      state;
  logic [15:0] tmr;
  logic [4:0]  phase;
  logic [11:0] tx_sr;
  logic [11:0] rx_sr;
  logic [2:0]  cfg_ch;
  logic [2:0]  prev_ch;
  logic        first;
  logic [2:0]  low_ch;
  logic [2:0]  next_ch;
  logic        any_ch;
  logic        above;

  // LTC2308 input word: single-ended, channel bits in the part's odd order
  function automatic logic [11:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'(UNIPOLAR), 1'b0, 6'b0};
  endfunction

  // Lowest set mask bit, and the next set bit above cfg_ch (wrapping to lowest)
  always_comb begin
    low_ch  = '0;
    next_ch = '0;
    any_ch  = 1'b0;
    above   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        low_ch = 3'(i);
        any_ch = 1'b1;
        if (3'(i) > cfg_ch) begin
          next_ch = 3'(i);
          above   = 1'b1;
        end
      end
    end
    if (!above) next_ch = low_ch;
  end

`ifdef ADC_AVG4_EN
  logic [13:0] acc   [NUM_CH];
  logic [1:0]  acc_n [NUM_CH];
  logic [13:0] sel_sum;
  logic [1:0]  sel_n;

  // Running sum for the channel the incoming result belongs to
  always_comb begin
    sel_sum = {2'b00, rx_sr};
    sel_n   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (prev_ch == 3'(i)) begin
        sel_sum = acc[i] + {2'b00, rx_sr};
        sel_n   = acc_n[i];
      end
    end
  end
`endif

  // Scan sequencer with registered SPI pins and result outputs
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tmr          <= '0;
      phase        <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      cfg_ch       <= '0;
      prev_ch      <= '0;
      first        <= 1'b1;
      sck          <= 1'b0;
      cs           <= 1'b1;
      mosi         <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      ch_data      <= '0;
      busy         <= 1'b0;
`ifdef ADC_AVG4_EN
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]   <= '0;
        acc_n[i] <= '0;
      end
`endif
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          first <= 1'b1;
          cs    <= 1'b1;
          sck   <= 1'b0;
          mosi  <= 1'b0;
          if (enable && any_ch) begin
            state  <= CONV;
            busy   <= 1'b1;
            cfg_ch <= low_ch;
            tx_sr  <= cfg_word(low_ch);
            tmr    <= 16'(CONV_WAIT - 1);
          end
        end
        CONV: begin
          if (tmr == '0) begin
            state <= SHIFT;
            cs    <= 1'b0;
            sck   <= 1'b0;
            mosi  <= tx_sr[11];
            tx_sr <= {tx_sr[10:0], 1'b0};
            tmr   <= 16'(CLK_DIV - 1);
            phase <= '0;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        SHIFT: begin
          if (tmr != '0) begin
            tmr <= tmr - 16'd1;
          end else begin
            tmr <= 16'(CLK_DIV - 1);
            if (phase == 5'd23) begin
              // Last high half done: drop sck, raise cs and publish the result
              state <= DONE;
              cs    <= 1'b1;
              sck   <= 1'b0;
              mosi  <= 1'b0;
              if (first) begin
                first <= 1'b0;
              end else begin
`ifdef ADC_AVG4_EN
                for (int i = 0; i < NUM_CH; i++) begin
                  if (prev_ch == 3'(i)) begin
                    if (sel_n == 2'd3) begin
                      acc[i]            <= '0;
                      acc_n[i]          <= '0;
                      ch_data[12*i +: 12] <= sel_sum[13:2];
                    end else begin
                      acc[i]   <= sel_sum;
                      acc_n[i] <= sel_n + 2'd1;
                    end
                  end
                end
                if (sel_n == 2'd3) begin
                  sample_data  <= sel_sum[13:2];
                  sample_ch    <= prev_ch;
                  sample_valid <= 1'b1;
                end
`else
                sample_data  <= rx_sr;
                sample_ch    <= prev_ch;
                sample_valid <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                  if (prev_ch == 3'(i)) ch_data[12*i +: 12] <= rx_sr;
                end
`endif
              end
            end else begin
              phase <= phase + 5'd1;
              sck   <= ~sck;
              if (!phase[0]) begin
                rx_sr <= {rx_sr[10:0], miso};
              end else begin
                mosi  <= tx_sr[11];
                tx_sr <= {tx_sr[10:0], 1'b0};
              end
            end
          end
        end
        DONE: begin
          // Result arriving next frame belongs to the channel just configured
          prev_ch <= cfg_ch;
          if (enable && any_ch) begin
            state  <= CONV;
            cfg_ch <= next_ch;
            tx_sr  <= cfg_word(next_ch);
            tmr    <= 16'(CONV_WAIT - 1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef ADC_AVG4_EN
            for (int i = 0; i < NUM_CH; i++) begin
              acc[i]   <= '0;
              acc_n[i] <= '0;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
